// File: rtl/mux4_rr_arbiter_if.sv
// Bus bundle between four requesters, the round-robin arbiter and the shared downstream consumer.
interface mux4_rr_arbiter_if #(
  parameter int DW = 8
);
  logic [3:0]      req_valid;
  logic [4*DW-1:0] req_data;
  logic [3:0]      req_ready;
  logic            out_valid;
  logic            out_ready;
  logic [DW-1:0]   out_data;
  logic [1:0]      sel;
  logic [3:0]      grant;

  // Arbiter side
  modport slave (
    input  req_valid, req_data, out_ready,
    output req_ready, out_valid, out_data, sel, grant
  );

  // Requesters plus consumer side
  modport master (
    output req_valid, req_data, out_ready,
    input  req_ready, out_valid, out_data, sel, grant
  );
endinterface

// File: rtl/mux4_rr_arbiter.sv
// Round-robin 4:1 arbiter feeding a one-deep registered output stage.
// Optional macro ARB_HOLD_EN lets a winner keep priority for up to MAX_HOLD consecutive beats.
module mux4_rr_arbiter #(
  parameter int DW       = 8,
  parameter int MAX_HOLD = 4
) (
  input logic              clk,
  input logic              rst_n,
  mux4_rr_arbiter_if.slave bus
);

  typedef enum logic {ST_EMPTY = 1'b0, ST_FULL = 1'b1} state_e;

  state_e        state_q, state_d;
  logic [DW-1:0] data_q, data_d;
  logic [1:0]    sel_q, sel_d;
  logic [3:0]    grant_q, grant_d;
  logic [1:0]    last_q, last_d;
  logic          load_en_s;
  logic          any_s;
  logic          xfer_s;
  logic [1:0]    win_s;
  logic [3:0]    ready_s;

  if (MAX_HOLD < 1 || MAX_HOLD > 15) begin : g_max_hold_range
    $error("MAX_HOLD must lie in 1..15");
  end

  // Search for the first valid requester starting one past the last pointer.
  always_comb begin
    win_s = 2'd0;
    any_s = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      if (!any_s && bus.req_valid[last_q + 2'(k)]) begin
        any_s = 1'b1;
        win_s = last_q + 2'(k);
      end else begin
        any_s = any_s;
      end
    end
  end

  assign load_en_s = (state_q == ST_EMPTY) || bus.out_ready;
  assign xfer_s    = load_en_s && any_s;
  assign ready_s   = xfer_s ? (4'b0001 << win_s) : 4'b0000;

`ifdef ARB_HOLD_EN
  logic [3:0] cnt_q, cnt_d;
  logic [1:0] held_s;
  logic [3:0] run_s;

  // While cnt_q is non-zero, last_q sits one below the held requester.
  assign held_s = last_q + 2'd1;
  assign run_s  = ((cnt_q != 4'd0) && (win_s == held_s)) ? (cnt_q + 4'd1) : 4'd1;

  // Pointer update: keep the winner on top until its run reaches MAX_HOLD.
  always_comb begin
    last_d = last_q;
    cnt_d  = cnt_q;
    if (xfer_s) begin
      if (run_s >= 4'(MAX_HOLD)) begin
        last_d = win_s;
        cnt_d  = 4'd0;
      end else begin
        last_d = win_s - 2'd1;
        cnt_d  = run_s;
      end
    end else if (load_en_s && (cnt_q != 4'd0)) begin
      last_d = held_s;
      cnt_d  = 4'd0;
    end else begin
      last_d = last_q;
      cnt_d  = cnt_q;
    end
  end

  // Hold run counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 4'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  // Pointer update: rotate after every accepted beat.
  always_comb begin
    last_d = last_q;
    if (xfer_s) begin
      last_d = win_s;
    end else begin
      last_d = last_q;
    end
  end
`endif

  // Output stage next state: load on transfer, empty on drain, otherwise hold.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    sel_d   = sel_q;
    grant_d = grant_q;
    case (state_q)
      ST_EMPTY: begin
        if (xfer_s) state_d = ST_FULL;
        else        state_d = ST_EMPTY;
      end
      ST_FULL: begin
        if (xfer_s)             state_d = ST_FULL;
        else if (bus.out_ready) state_d = ST_EMPTY;
        else                    state_d = ST_FULL;
      end
      default: state_d = ST_EMPTY;
    endcase
    if (xfer_s) begin
      data_d  = bus.req_data[int'(win_s)*DW +: DW];
      sel_d   = win_s;
      grant_d = 4'b0001 << win_s;
    end else if (state_d == ST_EMPTY) begin
      grant_d = 4'b0000;
    end else begin
      grant_d = grant_q;
    end
  end

  // State and output registers; reset restarts arbitration at requester 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      data_q  <= '0;
      sel_q   <= 2'b00;
      grant_q <= 4'b0000;
      last_q  <= 2'b11;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      sel_q   <= sel_d;
      grant_q <= grant_d;
      last_q  <= last_d;
    end
  end

  assign bus.req_ready = ready_s;
  assign bus.out_valid = (state_q == ST_FULL);
  assign bus.out_data  = data_q;
  assign bus.sel       = sel_q;
  assign bus.grant     = grant_q;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Scoreboard bench for mux4_rr_arbiter: a priority-list reference model predicts each accepted beat,
// a monitor pops and compares on every output drain.
module tb_mux4_rr_arbiter;
  localparam int DW       = 8;
  localparam int MAX_HOLD = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [3:0]      rv;
  logic [4*DW-1:0] rd;
  logic            ordy;

  mux4_rr_arbiter_if #(.DW(DW)) bus ();

  mux4_rr_arbiter #(.DW(DW), .MAX_HOLD(MAX_HOLD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  assign bus.req_valid = rv;
  assign bus.req_data  = rd;
  assign bus.out_ready = ordy;

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state: output occupancy, rotation pointer, held requester and its run length.
  int full_m = 0;
  int last_m = 3;
  int held_m = -1;
  int run_m  = 0;
  logic [DW+1:0] sb[$];
  int sel_log[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int model_winner(input logic [3:0] v);
    int start;
    start = (held_m >= 0) ? held_m : ((last_m + 1) % 4);
    for (int k = 0; k < 4; k++) begin
      if (v[(start + k) % 4]) return (start + k) % 4;
    end
    return -1;
  endfunction

  task automatic step(input logic [3:0] v, input logic r);
    @(posedge clk);
    #1;
    rv   = v;
    ordy = r;
  endtask

  // Reference model: advances at each edge using the inputs present at that edge.
  initial begin
    int w;
    bit le;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        full_m = 0; last_m = 3; held_m = -1; run_m = 0;
        sb.delete();
      end else begin
        w  = model_winner(rv);
        le = (full_m == 0) || ordy;
        if (w >= 0 && le) begin
          sb.push_back({rd[w*DW +: DW], 2'(w)});
          full_m = 1;
`ifdef ARB_HOLD_EN
          run_m = (w == held_m) ? run_m + 1 : 1;
          if (run_m >= MAX_HOLD) begin
            last_m = w; held_m = -1; run_m = 0;
          end else begin
            held_m = w;
          end
`else
          last_m = w;
`endif
        end else begin
          if (full_m != 0 && ordy) full_m = 0;
`ifdef ARB_HOLD_EN
          if (le && held_m >= 0) begin
            last_m = held_m; held_m = -1; run_m = 0;
          end
`endif
        end
      end
    end
  end

  // Handshake checker: req_ready and out_valid against the model every cycle.
  initial begin
    int w;
    bit le;
    logic [3:0] exp_rdy;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        w  = model_winner(rv);
        le = (full_m == 0) || ordy;
        exp_rdy = (w >= 0 && le) ? 4'(4'b0001 << w) : 4'b0000;
        chk("req_ready", 32'(bus.req_ready), 32'(exp_rdy));
        chk("out_valid", 32'(bus.out_valid), 32'(full_m));
        if (full_m == 0) chk("grant_idle", 32'(bus.grant), 32'd0);
      end
    end
  end

  // Monitor: pop the expected beat whenever the output stage drains.
  initial begin
    logic [DW+1:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_underflow: actual beat %0h with no expected beat at %0t", bus.out_data, $time);
        end else begin
          e = sb.pop_front();
          chk("out_data", 32'(bus.out_data), 32'(e[DW+1:2]));
          chk("sel", 32'(bus.sel), 32'(e[1:0]));
          chk("grant", 32'(bus.grant), 32'(4'b0001 << e[1:0]));
          sel_log.push_back(int'(bus.sel));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual time %0t required completion earlier", $time);
    $fatal(1, "timeout");
  end

  initial begin
    int exp1[5];
`ifdef ARB_HOLD_EN
    exp1 = '{0, 0, 0, 0, 1};
`else
    exp1 = '{0, 1, 2, 3, 0};
`endif
    rv = 4'b0000; rd = '0; ordy = 1'b0; rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_data", 32'(bus.out_data), 32'd0);
    chk("rst_sel", 32'(bus.sel), 32'd0);
    chk("rst_grant", 32'(bus.grant), 32'd0);
    chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // All four requesting with fixed data: rotation order.
    rd = 32'h44332211;
    sel_log.delete();
    repeat (8) step(4'b1111, 1'b1);
    for (int i = 0; i < 5; i++) begin
      if (i < sel_log.size()) chk("t1_order", 32'(sel_log[i]), 32'(exp1[i]));
      else                    chk("t1_len", 32'(sel_log.size()), 32'd5);
    end

    // Requesters 0 and 2 only: 1 and 3 must never be readied.
    repeat (8) begin
      rd = $urandom;
      step(4'b0101, 1'b1);
      @(negedge clk);
      chk("t2_no_odd", 32'(bus.req_ready & 4'b1010), 32'd0);
    end

    // Stall with 0x33 held, then drain and load requester 3 on the same edge.
    rd = 32'h44332211;
    step(4'b0100, 1'b1);
    step(4'b1000, 1'b0);
    repeat (5) begin
      @(negedge clk);
      chk("t3_hold_data", 32'(bus.out_data), 32'h33);
      chk("t3_hold_sel", 32'(bus.sel), 32'd2);
      chk("t3_hold_rdy", 32'(bus.req_ready), 32'd0);
    end
    step(4'b1000, 1'b1);
    @(negedge clk);
    chk("t3_pre_rdy", 32'(bus.req_ready), 32'h8);
    @(negedge clk);
    chk("t3_next_data", 32'(bus.out_data), 32'h44);
    chk("t3_next_sel", 32'(bus.sel), 32'd3);

    // Single one-cycle beat from requester 1.
    step(4'b0010, 1'b1);
    step(4'b0000, 1'b1);
    @(negedge clk);
    chk("t4_valid", 32'(bus.out_valid), 32'd1);
    chk("t4_sel", 32'(bus.sel), 32'd1);
    chk("t4_grant", 32'(bus.grant), 32'h2);
    @(negedge clk);
    chk("t4_empty", 32'(bus.out_valid), 32'd0);
    chk("t4_grant0", 32'(bus.grant), 32'd0);

    // Asynchronous reset while the output stage is full.
    step(4'b1111, 1'b0);
    step(4'b1111, 1'b0);
    @(posedge clk);
    #3;
    chk("t5_pre_full", 32'(bus.out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_valid", 32'(bus.out_valid), 32'd0);
    chk("t5_rst_data", 32'(bus.out_data), 32'd0);
    chk("t5_rst_sel", 32'(bus.sel), 32'd0);
    chk("t5_rst_grant", 32'(bus.grant), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    sel_log.delete();
    repeat (3) step(4'b1111, 1'b1);
    if (sel_log.size() > 0) chk("t5_first_grant", 32'(sel_log[0]), 32'd0);
    else                    chk("t5_first_len", 32'(sel_log.size()), 32'd1);

    // Randomized traffic with random downstream back-pressure.
    repeat (400) begin
      rd = $urandom;
      step(4'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0));
    end

    for (int i = 0; i < 20 && sb.size() != 0; i++) step(4'b0000, 1'b1);
    @(negedge clk);
    chk("drain_empty", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mux4_rr_arbiter.md
Name: mux4_rr_arbiter

Overview:
Round-robin arbiter and sequencer for a 4:1 multiplexer datapath. Four requesters (a, b, c, d → indices 0..3) present data beats with valid/ready handshakes. The block picks one requester per accepted beat, drives the mux select, and registers the chosen beat into a single-entry output stage with its own valid/ready handshake. It sits between four producer channels and one shared downstream consumer.

Parameters:
DW, 8, data width of each requester beat and of out_data.
MAX_HOLD, 4, maximum consecutive beats one requester may win back-to-back; used only when ARB_HOLD_EN is defined; legal range 1..15.

Ports:
clk  input  1  system clock, all state on rising edge.
rst_n  input  1  asynchronous active-low reset.
req_valid  input  4  per-requester beat valid; bit i = requester i.
req_data  input  4*DW  flat data bus; requester i occupies bits [i*DW +: DW].
req_ready  output  4  per-requester accept; at most one bit high per cycle.
out_valid  output  1  output stage holds a beat.
out_ready  input  1  downstream accepts the beat.
out_data  output  DW  registered selected beat.
sel  output  2  registered index of the requester whose beat is in out_data; drives the shared mux.
grant  output  4  registered one-hot copy of sel; 4'b0000 while out_valid = 0.

Behaviour:
- Reset (rst_n low, asynchronous): out_valid = 0, out_data = 0, sel = 2'b00, grant = 4'b0000, last pointer = 2'b11 (requester 0 has first priority), hold counter = 0. req_ready is combinational and therefore 0.
- load_en = !out_valid || out_ready. The output stage is a one-deep pipeline register; full throughput of one beat per cycle is allowed.
- Arbitration is combinational every cycle. Search starts at last+1 and proceeds mod 4 (e.g. last = 2 → order 3, 0, 1, 2). The winner w is the first index with req_valid set.
- req_ready[w] = load_en && |req_valid. All other bits are 0. req_ready never depends on req_ready. req_ready may depend on req_valid and out_ready.
- Transfer on a requester i: req_valid[i] && req_ready[i]. On the next edge: out_data ← req_data[w], sel ← w, grant ← onehot(w), out_valid ← 1, last ← w.
- Output handshake: when out_valid && out_ready and there is no new transfer, out_valid ← 0 and grant ← 0. out_data and sel hold their values.
- When out_valid && !out_ready, out_data, sel, grant, and last all hold, and req_ready = 0.
- Latency: a beat accepted at edge N is visible on out_data after edge N (1 cycle). Throughput is 1 beat/cycle when out_ready is held high.
- Output stage states: EMPTY (out_valid = 0) and FULL (out_valid = 1).
  - EMPTY → FULL on any transfer.
  - FULL → FULL on simultaneous drain and transfer.
  - FULL → EMPTY on drain without a transfer.
- No req_valid set: no grant. last does not change.
- Fairness: with all four requesting continuously and out_ready = 1, grants cycle 0, 1, 2, 3, 0 … A requester that drops valid is skipped with no bubble.
- Mid-operation reset: a beat held in the output stage is discarded. Arbitration restarts at requester 0.
- Requester data only needs to be stable in the cycle in which its req_ready is high.

Optional Feature:
ARB_HOLD_EN
- Defined: after a transfer from w, w keeps top priority on following transfers while req_valid[w] stays high. The hold counter increments per consecutive transfer from w. Once MAX_HOLD consecutive beats from w have transferred, last ← w and the counter clears, so the search resumes at w+1. A gap in req_valid[w] (w not winning) also clears the counter.
- Not defined: the grant rotates after every beat, and the hold counter and MAX_HOLD are unused (no logic).

Test Plan:
1. Reset, then req_valid = 4'b1111 with data a=0x11, b=0x22, c=0x33, d=0x44 and out_ready = 1 → out_data sequence 0x11, 0x22, 0x33, 0x44, 0x11; sel 0, 1, 2, 3, 0; one beat/cycle.
2. req_valid = 4'b0101 only, out_ready = 1 → grants alternate 0, 2, 0, 2. req_ready[1] and req_ready[3] are never high.
3. Output full with 0x33 (sel = 2) and out_ready = 0 for 5 cycles → out_data = 0x33, sel = 2, and req_ready = 0 for all 5 cycles. Raising out_ready → next beat from requester 3 loads on the same edge the 0x33 beat drains.
4. Single requester 1 valid for one cycle, out_ready = 1 → out_valid high for exactly one cycle with sel = 1 and grant = 4'b0010, then out_valid = 0 and grant = 0.
5. Assert rst_n = 0 asynchronously while out_valid = 1 → out_valid, out_data, grant, and sel clear immediately. After release, with all requesters valid, the first grant is requester 0.
6. ARB_HOLD_EN defined, MAX_HOLD = 4, all requesters valid, out_ready = 1 → grants 0, 0, 0, 0, 1, 1, 1, 1, 2 …; without the macro → 0, 1, 2, 3.
